// File: rtl/intc_pkg.sv
// ============================================================================
// Module   : intc_pkg
// Purpose  : Shared constants, state encoding and helpers for the intc block.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package intc_pkg;

    localparam int NSRC = 6;
    localparam int IDW  = 3;

    localparam logic [1:0] A_CTRL = 2'd0;
    localparam logic [1:0] A_MASK = 2'd1;
    localparam logic [1:0] A_PEND = 2'd2;
    localparam logic [1:0] A_STAT = 2'd3;

    localparam int CTRL_EN      = 0;
    localparam int CTRL_EDGE_LO = 8;
    localparam int CTRL_EDGE_HI = 13;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_REQ  = 1'b1
    } state_t;

    function automatic logic [NSRC-1:0] onehot(input logic [IDW-1:0] id);
        return {{(NSRC-1){1'b0}}, 1'b1} << id;
    endfunction

endpackage

`default_nettype wire

// File: rtl/intc_if.sv
// ============================================================================
// Module   : intc_if
// Purpose  : Register bus, IRQ lines and CPU handshake of the intc block.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface intc_if;
    import intc_pkg::*;

    logic [1:0]      addr;
    logic            we;
    logic [31:0]     data_i;
    logic [31:0]     data_o;
    logic [NSRC-1:0] src;
    logic [NSRC-1:0] hwint_o;
    logic            ack_i;
    logic            eoi_i;

    modport master (
        output addr, we, data_i, src, ack_i, eoi_i,
        input  data_o, hwint_o
    );

    modport slave (
        input  addr, we, data_i, src, ack_i, eoi_i,
        output data_o, hwint_o
    );

endinterface

`default_nettype wire

// File: rtl/intc_prio.sv
// ============================================================================
// Module   : intc_prio
// Purpose  : Nesting-aware priority pick: lowest index wins, sources at or
//            below the highest-priority in-service source are blocked.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module intc_prio
    import intc_pkg::*;
(
    input  logic [NSRC-1:0] cand,
    input  logic [NSRC-1:0] isr,
    output logic [NSRC-1:0] elig,
    output logic [IDW-1:0]  sel,
    output logic            any
);

    logic blocked;

    always_comb begin
        blocked = 1'b0;
        elig    = '0;
        for (int i = 0; i < NSRC; i++) begin
            blocked = blocked | isr[i];
            elig[i] = cand[i] & ~blocked;
        end
    end

    // Scan from the bottom up so the last hit is the lowest index.
    always_comb begin
        sel = '0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (elig[i]) begin
                sel = IDW'(i);
            end
        end
    end

    assign any = |elig;

endmodule

`default_nettype wire

// File: rtl/intc.sv
// ============================================================================
// Module   : intc
// Purpose  : Six-source interrupt controller with mask, edge/level pending,
//            nested priority and ack/EOI handshake towards the CPU.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module intc
    import intc_pkg::*;
(
    input  logic   clk,
    input  logic   reset,
    intc_if.slave  bus
);

    logic            en;
    logic [NSRC-1:0] edge_mode;
    logic [NSRC-1:0] mask;
    logic [NSRC-1:0] src_q;
    logic [NSRC-1:0] pend_edge;
    logic [NSRC-1:0] isr;
    logic [IDW-1:0]  cur_id;
    logic [NSRC-1:0] hwint;
    state_t          state;

    logic [NSRC-1:0] pend;
    logic [NSRC-1:0] pend_edge_next;
    logic [NSRC-1:0] w1c;
    logic [NSRC-1:0] cand;
    logic [NSRC-1:0] elig;
    logic [IDW-1:0]  sel;
    logic            any;
    logic [NSRC-1:0] isr_after_eoi;
    logic [NSRC-1:0] isr_next;

    state_t          state_next;
    logic [IDW-1:0]  cur_next;
    logic [NSRC-1:0] hwint_next;
    logic            ack_take;
    logic [NSRC-1:0] ack_vec;

    logic            wr_ctrl;
    logic            wr_mask;
    logic            wr_pend;
    logic [31:0]     rdata;
    logic            unused_data;

    assign wr_ctrl = bus.we && (bus.addr == A_CTRL);
    assign wr_mask = bus.we && (bus.addr == A_MASK);
    assign wr_pend = bus.we && (bus.addr == A_PEND);
    assign unused_data = &{1'b0, bus.data_i[31:14], bus.data_i[7:6]};

    // Level-mode bits follow the sampled line directly; only edge bits latch.
    assign pend = (edge_mode & pend_edge) | (~edge_mode & src_q);
    assign w1c  = wr_pend ? bus.data_i[NSRC-1:0] : '0;
    assign pend_edge_next = edge_mode & ((bus.src & ~src_q) | (pend_edge & ~(w1c | ack_vec)));

    assign cand = pend & mask & {NSRC{en}};

    intc_prio u_prio (
        .cand (cand),
        .isr  (isr),
        .elig (elig),
        .sel  (sel),
        .any  (any)
    );

    // EOI retires the highest-priority in-service bit before any ack sets a new one.
    assign isr_after_eoi = bus.eoi_i ? (isr & ~(isr & (~isr + {{(NSRC-1){1'b0}}, 1'b1}))) : isr;
    assign isr_next      = isr_after_eoi | ack_vec;

    always_ff @(posedge clk) begin
        if (!reset) begin
            en        <= 1'b0;
            edge_mode <= '0;
            mask      <= '0;
            src_q     <= '0;
            pend_edge <= '0;
            isr       <= '0;
        end else begin
            src_q     <= bus.src;
            pend_edge <= pend_edge_next;
            isr       <= isr_next;
            if (wr_ctrl) begin
                en        <= bus.data_i[CTRL_EN];
                edge_mode <= bus.data_i[CTRL_EDGE_HI:CTRL_EDGE_LO];
            end
            if (wr_mask) begin
                mask <= bus.data_i[NSRC-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state  <= S_IDLE;
            cur_id <= '0;
            hwint  <= '0;
        end else begin
            state  <= state_next;
            cur_id <= cur_next;
            hwint  <= hwint_next;
        end
    end

    // CUR_ID is frozen while requesting; newcomers wait for the return to IDLE.
    always_comb begin
        state_next = state;
        cur_next   = cur_id;
        case (state)
            S_IDLE: begin
                if (any) begin
                    state_next = S_REQ;
                    cur_next   = sel;
                end
            end
            S_REQ: begin
                if (bus.ack_i || !elig[cur_id]) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        ack_take   = (state == S_REQ) && bus.ack_i;
        ack_vec    = ack_take ? onehot(cur_id) : '0;
        hwint_next = (state_next == S_REQ) ? onehot(cur_next) : '0;
    end

    always_comb begin
        rdata = '0;
        case (bus.addr)
            A_CTRL:  rdata = {18'b0, edge_mode, 7'b0, en};
            A_MASK:  rdata = {26'b0, mask};
            A_PEND:  rdata = {26'b0, pend};
            A_STAT:  rdata = {15'b0, (state == S_REQ), 5'b0, cur_id, 2'b0, isr};
            default: rdata = '0;
        endcase
    end

    assign bus.data_o  = rdata;
    assign bus.hwint_o = hwint;

endmodule

`default_nettype wire

// File: tb/tb_intc.sv
// ============================================================================
// Module   : tb_intc
// Purpose  : Directed self-checking bench for the intc interrupt controller.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_intc;
    import intc_pkg::*;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    intc_if bus ();

    intc u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        bus.addr   = a;
        bus.we     = 1'b1;
        bus.data_i = d;
        tick();
        bus.we     = 1'b0;
    endtask

    task automatic chk_reg(input string tag, input logic [1:0] a, input logic [31:0] exp);
        bus.addr = a;
        #1;
        check(tag, bus.data_o, exp);
    endtask

    task automatic pulse_src(input logic [5:0] v);
        bus.src = v;
        tick();
        bus.src = 6'h00;
    endtask

    task automatic do_ack();
        bus.ack_i = 1'b1;
        tick();
        bus.ack_i = 1'b0;
    endtask

    task automatic do_eoi();
        bus.eoi_i = 1'b1;
        tick();
        bus.eoi_i = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1, "timeout");
    end

    initial begin
        checks     = 0;
        errors     = 0;
        reset      = 1'b0;
        bus.addr   = 2'd0;
        bus.we     = 1'b0;
        bus.data_i = 32'h0;
        bus.src    = 6'h00;
        bus.ack_i  = 1'b0;
        bus.eoi_i  = 1'b0;
        tick();
        tick();
        reset = 1'b1;

        // Reset values
        check("rst_hwint", {26'b0, bus.hwint_o}, 32'h0);
        chk_reg("rst_ctrl", A_CTRL, 32'h0);
        chk_reg("rst_mask", A_MASK, 32'h0);
        chk_reg("rst_pend", A_PEND, 32'h0);
        chk_reg("rst_stat", A_STAT, 32'h0);

        wr(A_CTRL, 32'h0000_0001);
        wr(A_MASK, 32'h0000_003F);
        tick();
        check("idle_hwint", {26'b0, bus.hwint_o}, 32'h0);
        chk_reg("idle_stat", A_STAT, 32'h0);
        bus.ack_i = 1'b1;
        tick();
        bus.ack_i = 1'b0;
        chk_reg("ack_idle_stat", A_STAT, 32'h0);

        // Edge request on source 0
        wr(A_CTRL, 32'h0000_0101);
        pulse_src(6'h01);
        chk_reg("edge_pend", A_PEND, 32'h01);
        check("edge_hwint_t", {26'b0, bus.hwint_o}, 32'h0);
        tick();
        check("edge_hwint_t1", {26'b0, bus.hwint_o}, 32'h01);
        chk_reg("edge_stat_req", A_STAT, 32'h0001_0000);
        do_ack();
        chk_reg("edge_ack_stat", A_STAT, 32'h01);
        chk_reg("edge_ack_pend", A_PEND, 32'h00);
        check("edge_ack_hwint", {26'b0, bus.hwint_o}, 32'h0);
        do_eoi();
        chk_reg("edge_eoi_stat", A_STAT, 32'h0);

        // Priority and nesting, all sources edge mode
        wr(A_CTRL, 32'h0000_3F01);
        pulse_src(6'h0A);
        chk_reg("prio_pend", A_PEND, 32'h0A);
        tick();
        check("prio_hwint", {26'b0, bus.hwint_o}, 32'h02);
        do_ack();
        chk_reg("prio_ack_stat", A_STAT, 32'h102);
        tick();
        check("prio_blocked", {26'b0, bus.hwint_o}, 32'h0);
        pulse_src(6'h01);
        tick();
        check("nest_hwint", {26'b0, bus.hwint_o}, 32'h01);
        do_ack();
        chk_reg("nest_ack_stat", A_STAT, 32'h003);
        do_eoi();
        chk_reg("nest_eoi1_stat", A_STAT, 32'h002);
        check("nest_eoi1_hwint", {26'b0, bus.hwint_o}, 32'h0);
        do_eoi();
        chk_reg("nest_eoi2_stat", A_STAT, 32'h000);
        tick();
        check("unblock_hwint", {26'b0, bus.hwint_o}, 32'h08);
        chk_reg("unblock_stat", A_STAT, 32'h0001_0300);
        do_ack();
        do_eoi();
        chk_reg("nest_clean_stat", A_STAT, 32'h300);

        // Level-mode withdrawal on source 2
        wr(A_CTRL, 32'h0000_0001);
        bus.src = 6'h04;
        tick();
        tick();
        check("lvl_hwint", {26'b0, bus.hwint_o}, 32'h04);
        bus.src = 6'h00;
        tick();
        check("wd_hwint_1", {26'b0, bus.hwint_o}, 32'h04);
        tick();
        check("wd_hwint_2", {26'b0, bus.hwint_o}, 32'h0);
        chk_reg("wd_stat", A_STAT, 32'h200);

        // W1C racing an edge on source 4, then mask during REQ
        wr(A_CTRL, 32'h0000_1001);
        bus.src = 6'h10;
        wr(A_PEND, 32'h0000_0010);
        bus.src = 6'h00;
        chk_reg("race_pend", A_PEND, 32'h10);
        tick();
        check("race_hwint", {26'b0, bus.hwint_o}, 32'h10);
        wr(A_MASK, 32'h0);
        tick();
        check("mask_hwint", {26'b0, bus.hwint_o}, 32'h0);
        chk_reg("mask_pend", A_PEND, 32'h10);
        wr(A_PEND, 32'h0000_0010);
        chk_reg("w1c_pend", A_PEND, 32'h00);

        // Simultaneous ack and eoi
        wr(A_MASK, 32'h3F);
        wr(A_CTRL, 32'h0000_3F01);
        pulse_src(6'h02);
        tick();
        do_ack();
        chk_reg("sim_pre_stat", A_STAT, 32'h102);
        pulse_src(6'h01);
        tick();
        check("sim_hwint", {26'b0, bus.hwint_o}, 32'h01);
        bus.ack_i = 1'b1;
        bus.eoi_i = 1'b1;
        tick();
        bus.ack_i = 1'b0;
        bus.eoi_i = 1'b0;
        chk_reg("sim_stat", A_STAT, 32'h001);
        check("sim_hwint_low", {26'b0, bus.hwint_o}, 32'h0);

        // Reset while a level request is presented
        wr(A_CTRL, 32'h0000_0001);
        do_eoi();
        bus.src = 6'h20;
        tick();
        tick();
        check("rreq_hwint", {26'b0, bus.hwint_o}, 32'h20);
        reset = 1'b0;
        tick();
        check("rreq_rst_hwint", {26'b0, bus.hwint_o}, 32'h0);
        chk_reg("rreq_rst_pend", A_PEND, 32'h0);
        chk_reg("rreq_rst_stat", A_STAT, 32'h0);
        chk_reg("rreq_rst_ctrl", A_CTRL, 32'h0);
        reset   = 1'b1;
        bus.src = 6'h00;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/intc.md
# intc

Six-source interrupt controller between the peripheral IRQ lines (timer0, timer1, four spare) and the CPU's `HWInt[7:2]` input. It latches or samples requests, applies a global enable and a per-source mask, and prioritises sources with nesting via an in-service register. It presents one request at a time to the CPU with an ack/EOI handshake. Its registers are reached through the bridge like any other device (`Addr[3:2]`, `WE`, `DataI`, `DataO`).

## Interface
- `NSRC`, default 6: number of sources. Fixed at 6 for this design.
- `clk` in 1: single clock; every register is clocked on its rising edge.
- `reset` in 1: **reset is synchronous and active-low.**
- `src` in 6: device IRQ lines. `src[0]` is the highest-priority source (timer0) and `src[5]` the lowest.
- `Addr` in 2 (`[3:2]`): register select from the bridge.
- `WE` in 1: register write enable.
- `DataI` in 32: write data.
- `DataO` in 32: read data; combinational from `Addr`.
- `hwint_o` out 6: one-hot request to CPU `HWInt[7:2]`; registered.
- `ack_i` in 1: the CPU has taken the presented interrupt (exception entry).
- `eoi_i` in 1: end of interrupt (eret).

## Operation
- **Registers**
  - Addr 0, CTRL: `[0]` EN (global enable); `[13:8]` EDGE (1 = rising-edge mode, 0 = level mode).
  - Addr 1, MASK: `[5:0]`, 1 = enabled.
  - Addr 2, PEND: `[5:0]`. Write-1-to-clear, applies to edge-mode bits only.
  - Addr 3, STAT, read-only: `[5:0]` ISR, `[10:8]` CUR_ID, `[16]` state. Writes to it are ignored.
  - Unused bits read 0.
- **Input sampling**: `src_q <= src` every cycle.
- **Pending, edge mode**: PEND bit set when `src & ~src_q`. Cleared by ack of that source or by a W1C write. Set wins over clear in the same cycle.
- **Pending, level mode**: PEND bit equals `src_q`. It is not latched, and W1C has no effect.
- **Arbitration**
  - `cand = PEND & MASK & {6{EN}}`.
  - `elig` = bits of `cand` whose index is below the lowest set ISR index. With ISR empty, `elig = cand`.
  - `sel` = lowest index in `elig`.
- **FSM states**: IDLE, REQ.
  - **IDLE**: if `elig != 0`, go to REQ and latch `CUR_ID <= sel`.
  - **REQ**:
    - `CUR_ID` is held stable. A higher-priority arrival does not retarget; it is re-arbitrated after return to IDLE.
    - On `ack_i`: set `ISR[CUR_ID]`, clear edge-mode `PEND[CUR_ID]`, go to IDLE.
    - Otherwise, if `elig[CUR_ID] == 0` (masked, disabled, level dropped, or W1C): withdraw and go to IDLE.
- **Output**: `hwint_o <= (next state == REQ) ? onehot(next CUR_ID) : 0`.
- **`eoi_i`**: clears the lowest-index set ISR bit. Ignored if ISR is 0.
- **`ack_i` in IDLE**: ignored.
- **Simultaneous `eoi_i` and `ack_i`**: the EOI clear is applied to the old ISR first, then the ack set is applied.
- **Writes to CTRL/MASK**: take effect at the next edge. Arbitration on the following cycle uses the new values.

## Timing
- **Reset values**: CTRL=0, MASK=0, PEND=0, ISR=0, CUR_ID=0, `src_q`=0, state IDLE, `hwint_o`=0. `DataO` reflects these reset values.
- **Request latency**: `src` first sampled high at edge t → PEND visible after t (both modes) → REQ entered and `hwint_o` high after t+1.
- **Ack**: `ack_i` at edge t → `hwint_o` low and ISR bit set after t. The next request can assert after t+1 at the earliest.
- **Withdrawal**: condition true before edge t → `hwint_o` low after t.
- **EOI**: `eoi_i` at edge t → ISR updated after t. An unblocked lower-priority request can assert after t+1.
- **Reset mid-operation**: all state returns to reset values at the next edge; no pending request survives.

## Structure
- Package `intc_pkg`:
  - `NSRC`.
  - Address constants `A_CTRL=0`, `A_MASK=1`, `A_PEND=2`, `A_STAT=3`.
  - State encoding IDLE/REQ.
  - CTRL field positions.
- Sub-module `intc_prio`: combinational. Inputs `cand`, ISR; outputs `elig`, `sel`, `any`. Used by both the FSM and the withdrawal check.

## Test plan
- **Reset**: EN=1, MASK=0x3F, `src=0` → `hwint_o=0`, STAT=0. Assert `reset=0` while in REQ → `hwint_o=0`, PEND=0 at the next cycle.
- **Edge request**: EDGE bit0=1, pulse `src[0]` for 1 cycle at edge t → PEND=0x01 after t, `hwint_o=0x01` after t+1. Then `ack_i` → ISR=0x01, PEND=0, `hwint_o=0`.
- **Priority/nesting**:
  - `src[1]` and `src[3]` raised together → `hwint_o=0x02`.
  - ack → ISR=0x02 → `hwint_o=0x08` is blocked.
  - `src[0]` pulses → `hwint_o=0x01` (nests).
  - ack → ISR=0x03.
  - eoi → ISR=0x02.
  - eoi → ISR=0, then `hwint_o=0x08`.
- **Withdrawal**: level-mode `src[2]` high → `hwint_o=0x04`. Drop `src[2]` before ack → `hwint_o=0` two cycles after `src` falls; ISR unchanged.
- **Mask/W1C race**: edge on `src[4]` in the same cycle as a W1C write 0x10 to PEND → PEND[4]=1 (set wins). Then write MASK=0 during REQ → `hwint_o=0`, PEND[4] still 1.
- **Simultaneous ack and eoi**: ISR=0x02, REQ on source 0, `ack_i=eoi_i=1` → ISR=0x01.
